// File: rtl/rfread_pkg.sv
// Shared definitions for the register-file read sequencer: FSM state encoding
// and the hardwired-zero register index.
package rfread_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        LAST = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rfread_fwd.sv
// Next-value selection for one operand register: write-port forwarding takes
// priority over the read-port capture, and index 0 always reads as zero.
module rfread_fwd
    import rfread_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  fwd_window,
    input  logic                  capture,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [DATA_WIDTH-1:0] cur_op,
    output logic [DATA_WIDTH-1:0] next_op
);

    logic is_zero;
    logic hit;

    always_comb begin
        is_zero = (idx == ADDR_WIDTH'(REG_ZERO));
        hit     = fwd_window && wr_en && (wr_addr == idx) && !is_zero;
        next_op = cur_op;
        if (hit) begin
            next_op = wr_data;
        end else if (capture) begin
            next_op = is_zero ? '0 : rd_data;
        end
    end

endmodule

// File: rtl/rfread_seq.sv
// Read-side sequencer: fetches rs1 then rs2 through the single synchronous
// register-file read port, keeping both operands coherent with the write port.
module rfread_seq
    import rfread_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  RFREAD_SEQ_Clk,
    input  logic                  RFREAD_SEQ_Reset_n,
    input  logic                  RFREAD_SEQ_Start,
    input  logic [ADDR_WIDTH-1:0] RFREAD_SEQ_Rs1,
    input  logic [ADDR_WIDTH-1:0] RFREAD_SEQ_Rs2,
    output logic [ADDR_WIDTH-1:0] RFREAD_SEQ_RF_Addr,
    input  logic [DATA_WIDTH-1:0] RFREAD_SEQ_RF_RdData,
    input  logic                  RFREAD_SEQ_Wr_En,
    input  logic [ADDR_WIDTH-1:0] RFREAD_SEQ_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] RFREAD_SEQ_Wr_Data,
    output logic                  RFREAD_SEQ_Busy,
    output logic                  RFREAD_SEQ_Valid,
    output logic [DATA_WIDTH-1:0] RFREAD_SEQ_Op1,
    output logic [DATA_WIDTH-1:0] RFREAD_SEQ_Op2
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] op1_nxt;
    logic [DATA_WIDTH-1:0] op2_nxt;
    logic                  fwd_window;

    // Forwarding is live from the first read cycle through the DONE edge.
    assign fwd_window = (state != IDLE);

    always_comb begin
        case (state)
            RD1:     RFREAD_SEQ_RF_Addr = rs1_q;
            RD2:     RFREAD_SEQ_RF_Addr = rs2_q;
            default: RFREAD_SEQ_RF_Addr = '0;
        endcase
    end

    rfread_fwd #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fwd_op1 (
        .fwd_window(fwd_window),
        .capture   (state == RD2),
        .idx       (rs1_q),
        .wr_en     (RFREAD_SEQ_Wr_En),
        .wr_addr   (RFREAD_SEQ_Wr_Addr),
        .wr_data   (RFREAD_SEQ_Wr_Data),
        .rd_data   (RFREAD_SEQ_RF_RdData),
        .cur_op    (op1_q),
        .next_op   (op1_nxt)
    );

    rfread_fwd #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fwd_op2 (
        .fwd_window(fwd_window),
        .capture   (state == LAST),
        .idx       (rs2_q),
        .wr_en     (RFREAD_SEQ_Wr_En),
        .wr_addr   (RFREAD_SEQ_Wr_Addr),
        .wr_data   (RFREAD_SEQ_Wr_Data),
        .rd_data   (RFREAD_SEQ_RF_RdData),
        .cur_op    (op2_q),
        .next_op   (op2_nxt)
    );

    always_ff @(posedge RFREAD_SEQ_Clk or negedge RFREAD_SEQ_Reset_n) begin
        if (!RFREAD_SEQ_Reset_n) begin
            state <= IDLE;
            rs1_q <= '0;
            rs2_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            op1_q <= op1_nxt;
            op2_q <= op2_nxt;
            case (state)
                IDLE: begin
                    if (RFREAD_SEQ_Start) begin
                        rs1_q <= RFREAD_SEQ_Rs1;
                        rs2_q <= RFREAD_SEQ_Rs2;
                        state <= RD1;
                    end
                end
                RD1:     state <= RD2;
                RD2:     state <= LAST;
                LAST:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign RFREAD_SEQ_Busy  = (state != IDLE);
    assign RFREAD_SEQ_Valid = (state == DONE);
    assign RFREAD_SEQ_Op1   = op1_q;
    assign RFREAD_SEQ_Op2   = op2_q;

endmodule

// File: tb/tb_rfread_seq.sv
// Scoreboard bench for rfread_seq: a register-file model with a registered
// read port drives the DUT; expected operands are queued at each accepted Start.
module tb_rfread_seq;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          busy;
    logic          valid;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;

    logic [DW-1:0] mem [32];
    exp_t          sb [$];
    int            checks = 0;
    int            failures = 0;
    int            n_push = 0;
    int            n_valid = 0;

    rfread_seq #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .RFREAD_SEQ_Clk      (clk),
        .RFREAD_SEQ_Reset_n  (rst_n),
        .RFREAD_SEQ_Start    (start),
        .RFREAD_SEQ_Rs1      (rs1),
        .RFREAD_SEQ_Rs2      (rs2),
        .RFREAD_SEQ_RF_Addr  (rf_addr),
        .RFREAD_SEQ_RF_RdData(rd_data),
        .RFREAD_SEQ_Wr_En    (wr_en),
        .RFREAD_SEQ_Wr_Addr  (wr_addr),
        .RFREAD_SEQ_Wr_Data  (wr_data),
        .RFREAD_SEQ_Busy     (busy),
        .RFREAD_SEQ_Valid    (valid),
        .RFREAD_SEQ_Op1      (op1),
        .RFREAD_SEQ_Op2      (op2)
    );

    always #5 clk = ~clk;

    // Register file with synchronous read: data for an address appears one cycle later.
    always @(posedge clk) begin
        rd_data <= mem[rf_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("op1", op1, e.e1);
                check("op2", op2, e.e2);
            end
        end
    end

    // Called at a negedge; returns at the negedge where the DUT sits in RD1.
    task automatic start_req(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [DW-1:0] e1, input logic [DW-1:0] e2, input bit push);
        exp_t e;
        start = 1'b1;
        rs1   = a;
        rs2   = b;
        if (push) begin
            e.e1 = e1;
            e.e2 = e2;
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        rs1   = '1;
        rs2   = '1;
    endtask

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload through the write port while idle (no forwarding in IDLE).
        rf_write(5'd3, 32'h11111111);
        rf_write(5'd7, 32'h22222222);
        rf_write(5'd9, 32'h0000000A);
        rf_write(5'd4, 32'h00000005);
        rf_write(5'd0, 32'hDEADBEEF);
        rf_write(5'd1, 32'h00000101);
        rf_write(5'd2, 32'h00000202);
        check("idle_op1", op1, 32'd0);

        // Basic fetch with address sequence and valid timing.
        start_req(5'd3, 5'd7, 32'h11111111, 32'h22222222, 1'b1);
        check("basic_addr_rd1", 32'(rf_addr), 32'd3);
        check("basic_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("basic_addr_rd2", 32'(rf_addr), 32'd7);
        check("basic_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        check("basic_addr_last", 32'(rf_addr), 32'd0);
        @(negedge clk);
        check("basic_valid", 32'(valid), 32'd1);
        check("basic_addr_done", 32'(rf_addr), 32'd0);
        @(negedge clk);
        check("basic_valid_off", 32'(valid), 32'd0);
        check("basic_idle", 32'(busy), 32'd0);

        // Reset asserted while in RD2 drops the request.
        start_req(5'd7, 5'd3, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_addr", 32'(rf_addr), 32'd0);
        check("midrst_op1", op1, 32'd0);
        check("midrst_op2", op2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        start_req(5'd3, 5'd7, 32'h11111111, 32'h22222222, 1'b1);
        wait_drain();

        // Forward on the Op2 capture edge beats the read data.
        start_req(5'd7, 5'd9, 32'h22222222, 32'h0000000B, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rf_write(5'd9, 32'h0000000B);
        wait_drain();

        // x0 reads as zero and is never forwarded.
        start_req(5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rf_write(5'd0, 32'h12345678);
        wait_drain();

        // Writes after capture keep updating the operand through the DONE edge.
        start_req(5'd4, 5'd3, 32'h00000006, 32'h11111111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rf_write(5'd4, 32'h00000006);
        check("late_done_valid", 32'(valid), 32'd1);
        rf_write(5'd4, 32'h00000007);
        check("late_done_edge", op1, 32'h00000007);
        rf_write(5'd4, 32'h00000008);
        check("late_idle_hold", op1, 32'h00000007);
        check("late_op2_hold", op2, 32'h11111111);

        // Start held high: only one acceptance per five cycles.
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            check("rej_busy", 32'(busy), 32'(i % 5 != 0));
            check("rej_valid_slot", 32'(valid), 32'(i % 5 == 4));
            start = 1'b1;
            rs1   = (i % 2 == 0) ? 5'd1 : 5'd2;
            rs2   = (i % 2 == 0) ? 5'd2 : 5'd1;
            if (i % 5 == 0) begin
                e.e1 = (i % 2 == 0) ? 32'h00000101 : 32'h00000202;
                e.e2 = (i % 2 == 0) ? 32'h00000202 : 32'h00000101;
                sb.push_back(e);
                n_push++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();

        check("valid_count", 32'(n_valid), 32'(n_push));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rfread_seq.md
Name: rfread_seq

Overview:
Read-side sequencer for the core's single-read-port register file. It is the reader counterpart of the register-file write-strobe path.
- On request, fetches rs1 then rs2 through the one synchronous read port.
- Forwards any write-strobe hit on a pending operand so the operands are coherent with the write port.
- Presents both operands with a one-cycle valid pulse to the execute stage.

Parameters:
DATA_WIDTH, 32, register/operand width
ADDR_WIDTH, 5, register index width (32 registers, x0 hardwired zero)

Ports:
RFREAD_SEQ_Clk  input  1  core clock, all state on rising edge
RFREAD_SEQ_Reset_n  input  1  asynchronous active-low reset
RFREAD_SEQ_Start  input  1  request operand fetch; sampled only in IDLE
RFREAD_SEQ_Rs1  input  ADDR_WIDTH  first source register index
RFREAD_SEQ_Rs2  input  ADDR_WIDTH  second source register index
RFREAD_SEQ_RF_Addr  output  ADDR_WIDTH  register file read address
RFREAD_SEQ_RF_RdData  input  DATA_WIDTH  register file read data, valid one cycle after RF_Addr
RFREAD_SEQ_Wr_En  input  1  register file write strobe (same cycle as the write)
RFREAD_SEQ_Wr_Addr  input  ADDR_WIDTH  write index
RFREAD_SEQ_Wr_Data  input  DATA_WIDTH  write data
RFREAD_SEQ_Busy  output  1  high in every state except IDLE
RFREAD_SEQ_Valid  output  1  one-cycle pulse, operands valid
RFREAD_SEQ_Op1  output  DATA_WIDTH  rs1 operand, held until next accepted Start
RFREAD_SEQ_Op2  output  DATA_WIDTH  rs2 operand, held until next accepted Start

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; latched rs1/rs2=0.
  - Op1=Op2=0; Valid=0; Busy=0; RF_Addr=0.
  - Applies mid-operation too; the pending request is dropped and no Valid is issued.
- States: IDLE, RD1, RD2, LAST, DONE. Registered, binary-encoded.
- IDLE: if Start=1, latch Rs1/Rs2 and go to RD1; otherwise stay.
- RD1: RF_Addr=rs1_q; next state RD2.
- RD2: RF_Addr=rs2_q; at the edge, Op1 captures RF_RdData (mem[rs1]); next state LAST.
- LAST: RF_Addr=0; at the edge, Op2 captures RF_RdData (mem[rs2]); next state DONE.
- DONE: Valid=1 for exactly this cycle; next state IDLE.
- RF_Addr is 0 in IDLE, LAST and DONE. It is combinational from state and the latched indices.
- Latency: Start sampled at edge N gives Valid high during the cycle after edge N+3. Throughput is one request per 5 cycles.
- Start while Busy (including DONE) is ignored, not queued. Rs1/Rs2 changes after acceptance have no effect.
- x0 rule: if the latched index is 0, the operand is forced to 0 at its capture edge. Forwarding never applies to index 0.
- Forwarding:
  - Applies on any edge in RD1, RD2, LAST or DONE.
  - Condition: Wr_En=1, Wr_Addr==rs1_q, and rs1_q!=0. Then Op1 takes Wr_Data at that edge.
  - The same rule applies to Op2 with rs2_q.
  - A forwarding hit overrides RF_RdData at the capture edge.
  - A write after capture still updates the operand, so Op1/Op2 always reflect the newest write up to and including the DONE edge.
- rs1_q==rs2_q: both operands follow the identical rules and end up equal.
- Op1/Op2 are not cleared on a new Start. They update only at capture or forward edges.

Decomposition:
- Shared package rfread_pkg:
  - state encoding constants: IDLE=3'd0, RD1=3'd1, RD2=3'd2, LAST=3'd3, DONE=3'd4.
  - REG_ZERO=5'd0.
- One sub-module: rfread_fwd (combinational hit detect plus next-operand mux), instantiated twice, once for Op1 and once for Op2.

Test Plan:
- Reset-mid-op: reset asserted in RD2 -> outputs immediately 0, state IDLE, no Valid; next Start completes normally.
- Basic: memory model mem[3]=0x11111111, mem[7]=0x22222222; Start with Rs1=3, Rs2=7 -> RF_Addr=3 then 7; Valid exactly 4 cycles after Start; Op1=0x11111111, Op2=0x22222222.
- x0: Rs1=0, Rs2=0, mem[0] model=0xDEADBEEF; also Wr_En=1 with Wr_Addr=0 during LAST -> Op1=Op2=0.
- Forward at capture: Rs2=9, mem[9]=0xA; Wr_En=1, Wr_Addr=9, Wr_Data=0xB at the LAST edge -> Op2=0xB.
- Late write: Rs1=4, mem[4]=0x5; write 0x6 to x4 in LAST -> Op1=0x6 when Valid is high.
- Busy rejection: Start held high continuously with Rs1=1/2 alternating -> requests accepted every 5 cycles only; each Valid carries the indices latched at acceptance.
